// File: rtl/hs_npu_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : hs_npu_result_writer
//  Description : Drains complete result rows from SIZE parallel output FIFOs
//                and writes each row to memory as BUS_WIDTH-wide beats at
//                consecutive byte addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module hs_npu_result_writer #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 16,
    parameter int BUS_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [31:0]                  base_addr,
    input  logic [31:0]                  num_rows,
    input  logic [SIZE*DATA_WIDTH-1:0]   row_data,
    input  logic [SIZE-1:0]              row_valid_i,
    output logic                         row_ready_o,
    output logic [31:0]                  mem_addr_o,
    output logic [BUS_WIDTH-1:0]         mem_data_o,
    output logic                         mem_valid_o,
    input  logic                         mem_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);

    // Elements per beat, beats per row and byte step between beats
    localparam int c_EPB    = BUS_WIDTH / DATA_WIDTH;
    localparam int c_BPR    = (SIZE * DATA_WIDTH) / BUS_WIDTH;
    localparam int c_BEAT_W = (c_BPR > 1) ? $clog2(c_BPR) : 1;

    localparam logic [31:0]         c_STEP      = 32'(BUS_WIDTH / 8);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(c_BPR - 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_WAIT_ROW = 2'd1;
    localparam logic [1:0] c_WRITE    = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]                 r_state;
    logic [31:0]                r_addr;
    logic [c_BEAT_W-1:0]        r_beat;
    logic [31:0]                r_rows;
    logic [31:0]                r_num_rows;
    logic [SIZE*DATA_WIDTH-1:0] r_row;

    logic                       w_all_valid;
    logic [31:0]                w_rows_next;
    logic [BUS_WIDTH-1:0]       w_beat_data;

    assign w_all_valid = &row_valid_i;
    assign w_rows_next = r_rows + 32'd1;

    // Gather the EPB elements of the current beat, lowest index in the LSBs
    for (genvar e = 0; e < c_EPB; e++) begin : g_beat_elem
        assign w_beat_data[e*DATA_WIDTH +: DATA_WIDTH] =
            r_row[(int'(r_beat) * c_EPB + e) * DATA_WIDTH +: DATA_WIDTH];
    end

    // Pop only when the whole row is present; the row is captured on that edge
    assign row_ready_o = (r_state == c_WAIT_ROW) && w_all_valid;
    assign mem_valid_o = (r_state == c_WRITE);
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = w_beat_data;
    assign busy_o      = (r_state != c_IDLE);
    assign done_o      = (r_state == c_DONE);

    // Job sequencing: accept start, pop rows, emit beats, count rows
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_addr     <= '0;
            r_beat     <= '0;
            r_rows     <= '0;
            r_num_rows <= '0;
            r_row      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (num_rows != 32'd0) begin
                            r_state    <= c_WAIT_ROW;
                            r_addr     <= base_addr;
                            r_rows     <= '0;
                            r_num_rows <= num_rows;
                        end else begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_WAIT_ROW: begin
                    if (w_all_valid) begin
                        r_row   <= row_data;
                        r_beat  <= '0;
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    if (mem_ready_i) begin
                        r_addr <= r_addr + c_STEP;
                        if (r_beat == c_LAST_BEAT) begin
                            r_beat  <= '0;
                            r_rows  <= w_rows_next;
                            r_state <= (w_rows_next == r_num_rows) ? c_DONE : c_WAIT_ROW;
                        end else begin
                            r_beat <= r_beat + 1'b1;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_npu_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hs_npu_result_writer
//  Description : Self-checking bench for hs_npu_result_writer with a write
//                scoreboard and per-scenario tasks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hs_npu_result_writer;

    localparam int SIZE = 8;
    localparam int DW   = 16;
    localparam int BW   = 32;
    localparam int EPB  = BW / DW;
    localparam int BPR  = SIZE * DW / BW;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [31:0]          base_addr;
    logic [31:0]          num_rows;
    logic [SIZE*DW-1:0]   row_data;
    logic [SIZE-1:0]      row_valid_i;
    logic                 row_ready_o;
    logic [31:0]          mem_addr_o;
    logic [BW-1:0]        mem_data_o;
    logic                 mem_valid_o;
    logic                 mem_ready_i;
    logic                 busy_o;
    logic                 done_o;

    typedef struct packed {
        logic [31:0]   a;
        logic [BW-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    int           n_cmp;
    int           n_err;
    int           pop_cnt;
    int           done_cnt;
    int           wr_cnt;
    logic [DW-1:0] vals [SIZE];
    logic          prev_stall;
    logic [31:0]   held_a;
    logic [BW-1:0] held_d;

    hs_npu_result_writer #(
        .SIZE       (SIZE),
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_addr   (base_addr),
        .num_rows    (num_rows),
        .row_data    (row_data),
        .row_valid_i (row_valid_i),
        .row_ready_o (row_ready_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_valid_o (mem_valid_o),
        .mem_ready_i (mem_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    // Monitor: counts pops/done pulses, checks writes against the scoreboard and stall stability
    always @(negedge clk) begin
        wr_t e;
        if (row_ready_o === 1'b1) begin
            pop_cnt++;
            n_cmp++;
            if (mem_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL pop_during_write: mem_valid_o=%b want 0", mem_valid_o);
            end
        end
        if (done_o === 1'b1) done_cnt++;
        if (prev_stall && rst_n === 1'b1) begin
            n_cmp++;
            if (mem_valid_o !== 1'b1 || mem_addr_o !== held_a || mem_data_o !== held_d) begin
                n_err++;
                $display("FAIL stall_hold: got v=%b a=%h d=%h want v=1 a=%h d=%h",
                         mem_valid_o, mem_addr_o, mem_data_o, held_a, held_d);
            end
        end
        if (mem_valid_o === 1'b1 && mem_ready_i === 1'b1) begin
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: got a=%h d=%h want no write", mem_addr_o, mem_data_o);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr_o !== e.a || mem_data_o !== e.d) begin
                    n_err++;
                    $display("FAIL write: got a=%h d=%h want a=%h d=%h",
                             mem_addr_o, mem_data_o, e.a, e.d);
                end
            end
        end
        prev_stall = (mem_valid_o === 1'b1 && mem_ready_i === 1'b0);
        held_a     = mem_addr_o;
        held_d     = mem_data_o;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        pop_cnt  = 0;
        done_cnt = 0;
        wr_cnt   = 0;
    endtask

    task automatic set_row(input logic [DW-1:0] first);
        for (int k = 0; k < SIZE; k++) begin
            vals[k] = first + DW'(k);
            row_data[k*DW +: DW] = first + DW'(k);
        end
    endtask

    // Expected beats for the row currently in vals[]
    task automatic push_row(input logic [31:0] addr);
        wr_t e;
        for (int b = 0; b < BPR; b++) begin
            e.a = addr + 32'(b * (BW / 8));
            e.d = '0;
            for (int j = 0; j < EPB; j++) e.d[j*DW +: DW] = vals[b*EPB + j];
            exp_q.push_back(e);
        end
    endtask

    task automatic start_job(input logic [31:0] base, input logic [31:0] n);
        base_addr = base;
        num_rows  = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Cycles counted from the negedge after the start edge until done_o is seen
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (done_o === 1'b1) break;
            cyc++;
        end
        if (cyc >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done_o want done_o within 200 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (row_ready_o !== 1'b0) begin n_err++; $display("FAIL rst_row_ready: got %b want 0", row_ready_o); end
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done_o); end
        n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr_o); end
        n_cmp++; if (mem_data_o !== '0) begin n_err++; $display("FAIL rst_data: got %h want 0", mem_data_o); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_single_row();
        int cyc;
        clear_counts();
        set_row(16'h0001);
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        exp_q.push_back('{a: 32'h1000, d: 32'h00020001});
        exp_q.push_back('{a: 32'h1004, d: 32'h00040003});
        exp_q.push_back('{a: 32'h1008, d: 32'h00060005});
        exp_q.push_back('{a: 32'h100C, d: 32'h00080007});
        start_job(32'h1000, 32'd1);
        n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy_o); end
        wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", cyc); end
        idle(3);
        n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL single_pops: got %0d want 1", pop_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL single_done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL single_pending: got %0d want 0", exp_q.size()); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_two_rows_late();
        int cyc;
        int guard;
        clear_counts();
        set_row(16'h0101);
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        push_row(32'h1000);
        start_job(32'h1000, 32'd2);
        guard = 0;
        @(negedge clk);
        while (row_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        row_valid_i = '0;
        set_row(16'h0201);
        push_row(32'h1010);
        repeat (BPR + 3) begin
            @(negedge clk);
            n_cmp++; if (row_ready_o !== 1'b0) begin n_err++; $display("FAIL late_no_pop: got %b want 0", row_ready_o); end
        end
        @(posedge clk);
        #1;
        row_valid_i = '1;
        wait_done(cyc);
        idle(2);
        n_cmp++; if (pop_cnt !== 2) begin n_err++; $display("FAIL late_pops: got %0d want 2", pop_cnt); end
        n_cmp++; if (wr_cnt !== 2 * BPR) begin n_err++; $display("FAIL late_writes: got %0d want %0d", wr_cnt, 2 * BPR); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL late_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int cyc;
        int guard;
        logic [BW-1:0] exp_d;
        clear_counts();
        set_row(16'h0A00);
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        push_row(32'h2000);
        exp_d = {vals[3], vals[2]};
        start_job(32'h2000, 32'd1);
        guard = 0;
        @(negedge clk);
        while (!(mem_valid_o === 1'b1 && mem_ready_i === 1'b1) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
        mem_ready_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            n_cmp++; if (mem_addr_o !== 32'h2004) begin n_err++; $display("FAIL stall_addr: got %h want 00002004", mem_addr_o); end
            n_cmp++; if (mem_data_o !== exp_d) begin n_err++; $display("FAIL stall_data: got %h want %h", mem_data_o, exp_d); end
            n_cmp++; if (row_ready_o !== 1'b0) begin n_err++; $display("FAIL stall_pop: got %b want 0", row_ready_o); end
        end
        @(posedge clk);
        #1;
        mem_ready_i = 1'b1;
        wait_done(cyc);
        idle(2);
        n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL stall_pops: got %0d want 1", pop_cnt); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL stall_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_partial_valid();
        int cyc;
        clear_counts();
        set_row(16'h0B00);
        row_valid_i = 8'h7F;
        mem_ready_i = 1'b1;
        push_row(32'h4000);
        start_job(32'h4000, 32'd1);
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (row_ready_o !== 1'b0) begin n_err++; $display("FAIL partial_pop: got %b want 0", row_ready_o); end
            n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL partial_write: got %b want 0", mem_valid_o); end
        end
        @(posedge clk);
        #1;
        row_valid_i = 8'hFF;
        @(negedge clk);
        n_cmp++; if (row_ready_o !== 1'b1) begin n_err++; $display("FAIL partial_last_pop: got %b want 1", row_ready_o); end
        wait_done(cyc);
        idle(2);
        n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL partial_pops: got %0d want 1", pop_cnt); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL partial_pending: got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_zero_rows();
        int cyc;
        clear_counts();
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        start_job(32'h5000, 32'd0);
        wait_done(cyc);
        n_cmp++; if (cyc !== 0) begin n_err++; $display("FAIL zero_latency: got %0d want 0", cyc); end
        idle(2);
        n_cmp++; if (pop_cnt !== 0) begin n_err++; $display("FAIL zero_pops: got %0d want 0", pop_cnt); end
        n_cmp++; if (wr_cnt !== 0) begin n_err++; $display("FAIL zero_writes: got %0d want 0", wr_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_held();
        int cyc;
        clear_counts();
        set_row(16'h0C00);
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        push_row(32'h6000);
        base_addr = 32'h6000;
        num_rows  = 32'd1;
        start     = 1'b1;
        wait_done(cyc);
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(10);
        n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL held_pops: got %0d want 1", pop_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_err++; $display("FAIL held_done_pulses: got %0d want 1", done_cnt); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL held_pending: got %0d want 0", exp_q.size()); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL held_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid_job();
        int cyc;
        int guard;
        clear_counts();
        set_row(16'h0D00);
        row_valid_i = '1;
        mem_ready_i = 1'b1;
        push_row(32'h3000);
        start_job(32'h3000, 32'd1);
        guard = 0;
        @(negedge clk);
        while (!(mem_valid_o === 1'b1 && mem_addr_o === 32'h3008) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (row_ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_row_ready: got %b want 0", row_ready_o); end
        n_cmp++; if (mem_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_mem_valid: got %b want 0", mem_valid_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL midrst_done: got %b want 0", done_o); end
        n_cmp++; if (mem_addr_o !== 32'h0) begin n_err++; $display("FAIL midrst_addr: got %h want 0", mem_addr_o); end
        n_cmp++; if (mem_data_o !== '0) begin n_err++; $display("FAIL midrst_data: got %h want 0", mem_data_o); end
        n_cmp++; if (exp_q.size() !== 1) begin n_err++; $display("FAIL midrst_remaining: got %0d want 1", exp_q.size()); end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        clear_counts();
        push_row(32'h3000);
        start_job(32'h3000, 32'd1);
        wait_done(cyc);
        n_cmp++; if (cyc !== 5) begin n_err++; $display("FAIL rerun_latency: got %0d want 5", cyc); end
        idle(2);
        n_cmp++; if (pop_cnt !== 1) begin n_err++; $display("FAIL rerun_pops: got %0d want 1", pop_cnt); end
        n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL rerun_pending: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        prev_stall  = 1'b0;
        held_a      = '0;
        held_d      = '0;
        clear_counts();
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        num_rows    = '0;
        row_data    = '0;
        row_valid_i = '0;
        mem_ready_i = 1'b0;

        test_reset();
        test_single_row();
        test_two_rows_late();
        test_stall();
        test_partial_valid();
        test_zero_rows();
        test_start_held();
        test_reset_mid_job();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
